// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle of the RAM arbiter: two request ports plus the
// completion/status signals returned to them.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, ack1, rdata, busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, ack1, rdata, busy
  );

endinterface

// File: rtl/ram_arbiter_arb_pick.sv
// Two-way request picker. Returns the index of the port to serve.
// RAM_ARB_RR_EN defined   : round robin, a tie goes to the port not served last.
// RAM_ARB_RR_EN undefined : fixed priority, port 0 always wins a tie.
module arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant
);

`ifdef RAM_ARB_RR_EN
  // Single requester wins outright; on a tie serve whoever was not last.
  assign grant = (req0 && req1) ? ~last : req1;
`else
  // Port 1 only wins when port 0 is idle; the last-served hint is ignored.
  logic last_unused;
  assign last_unused = last;
  assign grant = req1 && !req0;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM with registered output.
// Each access takes IDLE -> BUSY -> DONE; the owner is latched on leaving
// IDLE so requesters may change their inputs while the access is in flight.
// Arbitration policy is selected by RAM_ARB_RR_EN (see arb_pick).
//
//   state | meaning
//   IDLE  | no access; sample req0/req1 and latch the winner
//   BUSY  | drive the RAM with the latched owner (one enable high)
//   DONE  | ram_q valid; ack pulse to the owner, rdata = ram_q
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  state_t            state;
  state_t            state_nxt;
  logic              grant;
  logic              start;
  logic              last;
  logic              owner_idx;
  logic              owner_we;
  logic [ADDR_W-1:0] owner_addr;
  logic [DATA_W-1:0] owner_data;

  assign start = (state == IDLE) && (bus.req0 || bus.req1);

  arb_pick u_pick (
    .req0  (bus.req0),
    .req1  (bus.req1),
    .last  (last),
    .grant (grant)
  );

  // State register; reset abandons any access in flight without an ack.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Owner capture and last-served tracking on every IDLE -> BUSY transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_idx  <= 1'b0;
      owner_we   <= 1'b0;
      owner_addr <= '0;
      owner_data <= '0;
      last       <= 1'b1;
    end else if (start) begin
      owner_idx  <= grant;
      owner_we   <= grant ? bus.we1    : bus.we0;
      owner_addr <= grant ? bus.addr1  : bus.addr0;
      owner_data <= grant ? bus.wdata1 : bus.wdata0;
      last       <= grant;
    end
  end

  // Next state and all outputs; RAM drive is purely a function of state so a
  // write in BUSY still lands on the edge that applies reset.
  always_comb begin
    state_nxt = state;
    ram_addr  = '0;
    ram_data  = '0;
    ram_rden  = 1'b0;
    ram_wren  = 1'b0;
    bus.ack0  = 1'b0;
    bus.ack1  = 1'b0;
    bus.rdata = '0;
    bus.busy  = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = BUSY;
      end
      BUSY: begin
        state_nxt = DONE;
        ram_addr  = owner_addr;
        ram_data  = owner_data;
        ram_wren  = owner_we;
        ram_rden  = ~owner_we;
      end
      DONE: begin
        state_nxt = IDLE;
        bus.ack0  = ~owner_idx;
        bus.ack1  = owner_idx;
        bus.rdata = ram_q;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural registered-output RAM.
// Expected ack patterns for the tie test follow RAM_ARB_RR_EN.
module tb_ram_arbiter;

  logic       clk;
  logic       rst;
  logic       ram_init;
  logic [7:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_rden;
  logic       ram_wren;
  logic [7:0] ram_q;
  logic [7:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_rden (ram_rden),
    .ram_wren (ram_wren),
    .ram_q    (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: write on wren, registered read on rden.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10] <= 8'hA5;
      mem[8'h11] <= 8'h5A;
      ram_q <= 8'h00;
    end else begin
      if (ram_wren) mem[ram_addr] <= ram_data;
      if (ram_rden) ram_q <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input logic port, input logic req, input logic we,
                          input logic [7:0] addr, input logic [7:0] wdata);
    if (port) begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One complete access from IDLE: BUSY drive, DONE ack, back to IDLE.
  task automatic do_access(input string tag, input logic port, input logic we,
                           input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [7:0] exp_rdata);
    set_port(port, 1'b1, we, addr, wdata);
    tick();
    check({tag, " busy"},     bus.busy, 1);
    check({tag, " rden"},     ram_rden, !we);
    check({tag, " wren"},     ram_wren, we);
    check({tag, " ram_addr"}, ram_addr, addr);
    check({tag, " ram_data"}, ram_data, wdata);
    check({tag, " early ack"}, {bus.ack1, bus.ack0}, 0);
    tick();
    check({tag, " ack0"}, bus.ack0, !port);
    check({tag, " ack1"}, bus.ack1, port);
    check({tag, " done enables"}, {ram_rden, ram_wren}, 0);
    check({tag, " done addr"}, ram_addr, 0);
    if (!we) check({tag, " rdata"}, bus.rdata, exp_rdata);
    set_port(port, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check({tag, " idle busy"}, bus.busy, 0);
    check({tag, " idle ack"}, {bus.ack1, bus.ack0}, 0);
  endtask

  initial begin
    rst      = 1'b1;
    ram_init = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    ram_init = 1'b0;
    rst      = 1'b0;

    check("reset busy", bus.busy, 0);
    check("reset acks", {bus.ack1, bus.ack0}, 0);
    check("reset enables", {ram_rden, ram_wren}, 0);
    check("reset ram_addr", ram_addr, 0);

    // Basic read, write, read-back of the written location.
    do_access("rd0 10", 1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
    do_access("wr1 20", 1'b1, 1'b1, 8'h20, 8'h3C, 8'h00);
    do_access("rd0 20", 1'b0, 1'b0, 8'h20, 8'h00, 8'h3C);

    // Address changes during BUSY must not affect the access in flight.
    set_port(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    tick();
    bus.addr0 = 8'h11;
    check("addr hold busy", ram_addr, 8'h10);
    tick();
    check("addr hold ack0", bus.ack0, 1);
    check("addr hold rdata", bus.rdata, 8'hA5);
    set_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();

    // Both ports held: one access every 3 cycles, pattern depends on policy.
    do_reset();
    set_port(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    set_port(1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
    for (int c = 1; c <= 9; c++) begin
      tick();
      check($sformatf("tie c%0d ack0", c), bus.ack0, (c % 3 == 2) && !(RR && c == 5));
      check($sformatf("tie c%0d ack1", c), bus.ack1, RR && c == 5);
      if (c % 3 == 2)
        check($sformatf("tie c%0d rdata", c), bus.rdata, (RR && c == 5) ? 8'h3C : 8'hA5);
    end
    set_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("tie drained", bus.busy, 0);

    // Port 0 arrives while port 1 is in BUSY: waits, then served next.
    set_port(1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    set_port(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    check("late req owner", ram_addr, 8'h20);
    tick();
    check("late req ack1", bus.ack1, 1);
    check("late req no ack0", bus.ack0, 0);
    set_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("late req idle", bus.busy, 0);
    tick();
    check("late req busy addr", ram_addr, 8'h10);
    check("late req busy rden", ram_rden, 1);
    check("late req busy ack0", bus.ack0, 0);
    tick();
    check("late req ack0", bus.ack0, 1);
    check("late req rdata", bus.rdata, 8'hA5);
    set_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();

    // Reset during a BUSY read: abandoned, then the held request restarts.
    set_port(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    tick();
    check("rst rd busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst rd state", bus.busy, 0);
    check("rst rd ack", {bus.ack1, bus.ack0}, 0);
    check("rst rd enables", {ram_rden, ram_wren}, 0);
    tick();
    check("rst rd restart rden", ram_rden, 1);
    check("rst rd restart ack", bus.ack0, 0);
    tick();
    check("rst rd restart ack0", bus.ack0, 1);
    check("rst rd restart rdata", bus.rdata, 8'hA5);
    set_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();

    // Reset during a BUSY write: the write lands, no ack follows.
    set_port(1'b1, 1'b1, 1'b1, 8'h30, 8'h77);
    tick();
    check("rst wr wren", ram_wren, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    check("rst wr enables", {ram_rden, ram_wren}, 0);
    check("rst wr ack", {bus.ack1, bus.ack0}, 0);
    tick();
    check("rst wr no late ack", {bus.ack1, bus.ack0}, 0);
    do_access("rd0 30", 1'b0, 1'b0, 8'h30, 8'h00, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
